// File: rtl/mc0512_memctl.sv
// Byte-wide core memory responder onto a 512K x 16 async SRAM with programmable wait states.
// Optional write protection of 20'hF0000-20'hFFFFF is enabled by defining MC0512_ROM_PROTECT_EN.
module mc0512_memctl #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic [19:0] address,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic        ce,
  output logic        busy,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_d_o,
  input  logic [15:0] sram_d_i,
  output logic        sram_d_t,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
`ifdef MC0512_ROM_PROTECT_EN
  ,
  output logic        rom_wr_hit
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, STROBE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [19:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_d;
  logic               ce_d, busy_d, d_t_d, ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d;
  logic               start, strobe, wr_ok;
`ifdef MC0512_ROM_PROTECT_EN
  logic               rom_q, rom_d, hit_d;
`endif

  // The SRAM only ever sees the copies latched when the access started.
  assign sram_addr = addr_q[19:1];
  assign sram_d_o  = {wdata_q, wdata_q};

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata;
    ce_d    = 1'b0;
    busy_d  = 1'b0;
    d_t_d   = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    start   = 1'b0;
    strobe  = 1'b0;
    wr_ok   = we;
`ifdef MC0512_ROM_PROTECT_EN
    rom_d   = rom_q;
    hit_d   = 1'b0;
    wr_ok   = we && (address[19:16] != 4'hF);
`endif

    unique case (state_q)
      IDLE:   start = en;
      SETUP, WAIT: begin
        busy_d = 1'b1;
        d_t_d  = sram_d_t;
        ce_n_d = sram_ce_n;
        oe_n_d = sram_oe_n;
        we_n_d = sram_we_n;
        lb_n_d = sram_lb_n;
        ub_n_d = sram_ub_n;
        if (state_q == SETUP) begin
          if (WAIT_STATES == 0) begin
            strobe = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end else if (cnt_q == CNT_W'(1)) begin
          strobe = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        start = en;
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Write strobe releases on entering STROBE; data stays driven for hold.
    if (strobe) begin
      state_d = STROBE;
      ce_d    = 1'b1;
      we_n_d  = 1'b1;
      if (!we_q) rdata_d = addr_q[0] ? sram_d_i[15:8] : sram_d_i[7:0];
`ifdef MC0512_ROM_PROTECT_EN
      hit_d   = rom_q;
`endif
    end

    if (start) begin
      state_d = SETUP;
      busy_d  = 1'b1;
      addr_d  = address;
      we_d    = we;
      wdata_d = wdata;
      ce_n_d  = 1'b0;
`ifdef MC0512_ROM_PROTECT_EN
      rom_d   = we && !wr_ok;
`endif
      if (we) begin
        lb_n_d = address[0];
        ub_n_d = !address[0];
        d_t_d  = wr_ok;
        we_n_d = !wr_ok;
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata     <= 8'hFF;
      ce        <= 1'b0;
      busy      <= 1'b0;
      sram_d_t  <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
`ifdef MC0512_ROM_PROTECT_EN
      rom_q      <= 1'b0;
      rom_wr_hit <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata     <= rdata_d;
      ce        <= ce_d;
      busy      <= busy_d;
      sram_d_t  <= d_t_d;
      sram_ce_n <= ce_n_d;
      sram_oe_n <= oe_n_d;
      sram_we_n <= we_n_d;
      sram_lb_n <= lb_n_d;
      sram_ub_n <= ub_n_d;
`ifdef MC0512_ROM_PROTECT_EN
      rom_q      <= rom_d;
      rom_wr_hit <= hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_mc0512_memctl.sv
// Directed bench for mc0512_memctl: four instances with WAIT_STATES 0..3 share one SRAM model.
// ROM-protect checks are included when MC0512_ROM_PROTECT_EN is defined.
module tb_mc0512_memctl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        en_a        [4];
  logic [19:0] address_a   [4];
  logic [7:0]  wdata_a     [4];
  logic        we_a        [4];
  logic [7:0]  rdata_a     [4];
  logic        ce_a        [4];
  logic        busy_a      [4];
  logic [18:0] sram_addr_a [4];
  logic [15:0] sram_d_o_a  [4];
  logic [15:0] sram_d_i_a  [4];
  logic        sram_d_t_a  [4];
  logic        sram_ce_n_a [4];
  logic        sram_oe_n_a [4];
  logic        sram_we_n_a [4];
  logic        sram_lb_n_a [4];
  logic        sram_ub_n_a [4];
`ifdef MC0512_ROM_PROTECT_EN
  logic        rom_wr_hit_a [4];
`endif

  logic [15:0] mem [0:524287];
  logic        mem_ready = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mc0512_memctl #(.WAIT_STATES(g)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .en        (en_a[g]),
      .address   (address_a[g]),
      .wdata     (wdata_a[g]),
      .we        (we_a[g]),
      .rdata     (rdata_a[g]),
      .ce        (ce_a[g]),
      .busy      (busy_a[g]),
      .sram_addr (sram_addr_a[g]),
      .sram_d_o  (sram_d_o_a[g]),
      .sram_d_i  (sram_d_i_a[g]),
      .sram_d_t  (sram_d_t_a[g]),
      .sram_ce_n (sram_ce_n_a[g]),
      .sram_oe_n (sram_oe_n_a[g]),
      .sram_we_n (sram_we_n_a[g]),
      .sram_lb_n (sram_lb_n_a[g]),
      .sram_ub_n (sram_ub_n_a[g])
`ifdef MC0512_ROM_PROTECT_EN
      ,
      .rom_wr_hit(rom_wr_hit_a[g])
`endif
    );
    assign sram_d_i_a[g] = sram_oe_n_a[g] ? 16'h0000 : mem[sram_addr_a[g]];
  end

  // SRAM model: preload once, then store selected lanes while the write strobe is low.
  always @(posedge clock) begin
    if (!mem_ready) begin
      mem[19'h7FFF8] <= 16'hEA90;
      mem[19'h00200] <= 16'h5AA5;
      mem[19'h7FFFF] <= 16'hB42D;
      mem[19'h78008] <= 16'h7788;
      mem_ready      <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!sram_ce_n_a[i] && !sram_we_n_a[i] && sram_d_t_a[i]) begin
          if (!sram_lb_n_a[i]) mem[sram_addr_a[i]][7:0]  <= sram_d_o_a[i][7:0];
          if (!sram_ub_n_a[i]) mem[sram_addr_a[i]][15:8] <= sram_d_o_a[i][15:8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ce_cnt;
    int strobes_after;
    bit seen_ce;

    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en_a[i] = 1'b0; address_a[i] = '0; wdata_a[i] = '0; we_a[i] = 1'b0;
    end
    repeat (3) tick();

    // Reset state
    check("rst_ce",    32'(ce_a[1]), 32'h0);
    check("rst_busy",  32'(busy_a[1]), 32'h0);
    check("rst_rdata", 32'(rdata_a[1]), 32'hFF);
    check("rst_strb",  32'({sram_ce_n_a[1], sram_oe_n_a[1], sram_we_n_a[1], sram_lb_n_a[1], sram_ub_n_a[1], sram_d_t_a[1]}), 32'h3E);
    check("rst_addr",  32'(sram_addr_a[1]), 32'h0);

    // First access after reset release, WAIT_STATES=1
    address_a[1] = 20'hFFFF0; en_a[1] = 1'b1;
    reset_n = 1'b1;
    tick();
    check("t1_c1_ce",   32'(ce_a[1]), 32'h0);
    check("t1_c1_busy", 32'(busy_a[1]), 32'h1);
    check("t1_c1_strb", 32'({sram_ce_n_a[1], sram_oe_n_a[1], sram_we_n_a[1], sram_lb_n_a[1], sram_ub_n_a[1]}), 32'h04);
    check("t1_c1_addr", 32'(sram_addr_a[1]), 32'h7FFF8);
    tick();
    check("t1_c2_ce",   32'(ce_a[1]), 32'h0);
    tick();
    check("t1_c3_ce",    32'(ce_a[1]), 32'h1);
    check("t1_c3_rdata", 32'(rdata_a[1]), 32'h90);
    en_a[1] = 1'b0;
    tick();
    check("t1_idle_ce",   32'(ce_a[1]), 32'h0);
    check("t1_idle_busy", 32'(busy_a[1]), 32'h0);
    check("t1_idle_cen",  32'(sram_ce_n_a[1]), 32'h1);

    // Back-to-back reads, WAIT_STATES=0
    address_a[0] = 20'h00401; en_a[0] = 1'b1;
    tick();
    check("t2_c1_ce",    32'(ce_a[0]), 32'h0);
    check("t2_c1_lanes", 32'({sram_lb_n_a[0], sram_ub_n_a[0]}), 32'h0);
    check("t2_c1_addr",  32'(sram_addr_a[0]), 32'h00200);
    tick();
    check("t2_c2_ce",    32'(ce_a[0]), 32'h1);
    check("t2_c2_rdata", 32'(rdata_a[0]), 32'h5A);
    tick();
    check("t2_c3_ce",    32'(ce_a[0]), 32'h0);
    tick();
    check("t2_c4_ce",    32'(ce_a[0]), 32'h1);
    // Top of the byte space, upper lane
    address_a[0] = 20'hFFFFF;
    tick();
    check("bnd_addr",  32'(sram_addr_a[0]), 32'h7FFFF);
    tick();
    check("bnd_ce",    32'(ce_a[0]), 32'h1);
    check("bnd_rdata", 32'(rdata_a[0]), 32'hB4);
    en_a[0] = 1'b0;
    tick();
    check("bnd_busy",  32'(busy_a[0]), 32'h0);

    // Write then read back, WAIT_STATES=2
    address_a[2] = 20'h01234; wdata_a[2] = 8'hC3; we_a[2] = 1'b1; en_a[2] = 1'b1;
    tick();
    check("t3_c1_wen",   32'(sram_we_n_a[2]), 32'h0);
    check("t3_c1_lanes", 32'({sram_lb_n_a[2], sram_ub_n_a[2]}), 32'h1);
    check("t3_c1_dt",    32'(sram_d_t_a[2]), 32'h1);
    check("t3_c1_do",    32'(sram_d_o_a[2]), 32'hC3C3);
    check("t3_c1_oen",   32'(sram_oe_n_a[2]), 32'h1);
    tick();
    check("t3_c2_wen",   32'(sram_we_n_a[2]), 32'h0);
    tick();
    check("t3_c3_wen",   32'(sram_we_n_a[2]), 32'h0);
    tick();
    check("t3_c4_wen",   32'(sram_we_n_a[2]), 32'h1);
    check("t3_c4_ce",    32'(ce_a[2]), 32'h1);
    check("t3_c4_dt",    32'(sram_d_t_a[2]), 32'h1);
    check("t3_c4_rdata", 32'(rdata_a[2]), 32'hFF);
    en_a[2] = 1'b0; we_a[2] = 1'b0;
    tick();
    check("t3_c5_dt",    32'(sram_d_t_a[2]), 32'h0);
    en_a[2] = 1'b1;
    repeat (3) tick();
    check("t3_rd_pre_ce", 32'(ce_a[2]), 32'h0);
    tick();
    check("t3_rd_ce",    32'(ce_a[2]), 32'h1);
    check("t3_rd_rdata", 32'(rdata_a[2]), 32'hC3);
    en_a[2] = 1'b0;
    tick();

    // en dropped during WAIT, WAIT_STATES=3
    address_a[3] = 20'h00401; en_a[3] = 1'b1;
    tick();
    tick();
    en_a[3] = 1'b0;
    ce_cnt = 0; strobes_after = 0; seen_ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (seen_ce && (!sram_ce_n_a[3] || !sram_oe_n_a[3] || !sram_we_n_a[3])) strobes_after++;
      if (ce_a[3]) begin
        ce_cnt++;
        seen_ce = 1'b1;
      end
    end
    check("t4_ce_cnt",  32'(ce_cnt), 32'd1);
    check("t4_strobes", 32'(strobes_after), 32'd0);
    check("t4_busy",    32'(busy_a[3]), 32'h0);
    check("t4_rdata",   32'(rdata_a[3]), 32'h5A);
    en_a[3] = 1'b1;
    tick();
    check("t4_resume",  32'(sram_ce_n_a[3]), 32'h0);

    // Asynchronous reset in the middle of a write
    address_a[2] = 20'h00002; wdata_a[2] = 8'h55; we_a[2] = 1'b1; en_a[2] = 1'b1;
    tick();
    tick();
    check("t5_pre_wen", 32'(sram_we_n_a[2]), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_wen",  32'(sram_we_n_a[2]), 32'h1);
    check("t5_ce",   32'(ce_a[2]), 32'h0);
    check("t5_busy", 32'(busy_a[2]), 32'h0);
    check("t5_dt",   32'(sram_d_t_a[2]), 32'h0);
    en_a[2] = 1'b0; en_a[3] = 1'b0; we_a[2] = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    ce_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ce_a[2] || ce_a[3]) ce_cnt++;
    end
    check("t5_no_ce", 32'(ce_cnt), 32'd0);

`ifdef MC0512_ROM_PROTECT_EN
    // Dropped write into the protected region, WAIT_STATES=1
    address_a[1] = 20'hF0010; wdata_a[1] = 8'h11; we_a[1] = 1'b1; en_a[1] = 1'b1;
    tick();
    check("rom_c1_wen", 32'(sram_we_n_a[1]), 32'h1);
    check("rom_c1_dt",  32'(sram_d_t_a[1]), 32'h0);
    tick();
    check("rom_c2_wen", 32'(sram_we_n_a[1]), 32'h1);
    tick();
    check("rom_c3_ce",  32'(ce_a[1]), 32'h1);
    check("rom_c3_hit", 32'(rom_wr_hit_a[1]), 32'h1);
    en_a[1] = 1'b0; we_a[1] = 1'b0;
    tick();
    check("rom_c4_hit", 32'(rom_wr_hit_a[1]), 32'h0);
    en_a[1] = 1'b1;
    repeat (3) tick();
    check("rom_rd_ce",    32'(ce_a[1]), 32'h1);
    check("rom_rd_rdata", 32'(rdata_a[1]), 32'h88);
    check("rom_rd_hit",   32'(rom_wr_hit_a[1]), 32'h0);
    en_a[1] = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
